// File: rtl/exe_muldiv_iter_pkg.sv
// Shared encodings for the iterative M-extension unit: funct3 opcodes, FSM states
// and opcode classification helpers.
package muldiv_defs;

  typedef enum logic [2:0] {
    INST_MUL    = 3'b000,
    INST_MULH   = 3'b001,
    INST_MULHSU = 3'b010,
    INST_MULHU  = 3'b011,
    INST_DIV    = 3'b100,
    INST_DIVU   = 3'b101,
    INST_REM    = 3'b110,
    INST_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    CALC  = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } state_e;

  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] f);
    return f[2] & f[1];
  endfunction

  function automatic logic is_signed_op1(input logic [2:0] f);
    return (f == INST_MULH) || (f == INST_MULHSU) || (f == INST_DIV) || (f == INST_REM);
  endfunction

  function automatic logic is_signed_op2(input logic [2:0] f);
    return (f == INST_MULH) || (f == INST_DIV) || (f == INST_REM);
  endfunction

endpackage

// File: rtl/exe_muldiv_iter_if.sv
// Execute-stage <-> muldiv unit bundle; master is the execute stage, slave is the unit.
interface exe_muldiv_iter_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic            flush_i;
  logic            stall_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, funct3_i, op1_i, op2_i, flush_i,
    input  stall_o, busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, funct3_i, op1_i, op2_i, flush_i,
    output stall_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/exe_muldiv_iter_step.sv
// One CALC iteration: BPC shift-add multiply bits or BPC restoring-divide quotient bits.
// acc holds {hi, lo}: product accumulator / multiplier, or remainder / dividend-quotient.
module muldiv_step #(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic              div_op,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN-1:0] acc_next
);

  logic [2*XLEN-1:0] work;
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     diff;
  logic [XLEN:0]     sum;

  always_comb begin
    work    = acc;
    shifted = '0;
    diff    = '0;
    sum     = '0;
    for (int i = 0; i < BPC; i++) begin
      if (div_op) begin
        shifted = {work[2*XLEN-1:XLEN], work[XLEN-1]};
        diff    = shifted - {1'b0, operand};
        // remainder stays below the divisor, so a non-borrowing diff fits in XLEN bits
        if (!diff[XLEN]) begin
          work = {diff[XLEN-1:0], work[XLEN-2:0], 1'b1};
        end else begin
          work = {shifted[XLEN-1:0], work[XLEN-2:0], 1'b0};
        end
      end else begin
        sum  = {1'b0, work[2*XLEN-1:XLEN]} + {1'b0, (work[0] ? operand : {XLEN{1'b0}})};
        work = {sum, work[XLEN-1:1]};
      end
    end
    acc_next = work;
  end

endmodule

// File: rtl/exe_muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide: stalls the execute stage for XLEN/BPC+3 cycles
// (1 cycle for divide-by-zero / signed overflow), then strobes done_o with the rd value.
module exe_muldiv_iter
  import muldiv_defs::*;
#(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input logic              clk_i,
  input logic              rst_i,
  exe_muldiv_iter_if.slave bus
);

  localparam int NSTEP = XLEN / BPC;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CW-1:0]   CNT_INIT = CW'(NSTEP - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state, state_nxt;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   op1_q, op2_q, divisor_q, res_q;
  logic [2*XLEN-1:0] acc_q, acc_step;
  logic [CW-1:0]     cnt_q;
  logic              neg_q, neg_r;

  logic              accept, div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;
  logic              sgn1, sgn2;
  logic [XLEN-1:0]   mag1, mag2;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  assign accept   = bus.start_i & ~bus.flush_i;
  assign div_zero = is_div(bus.funct3_i) && (bus.op2_i == '0);
  assign div_ovf  = is_div(bus.funct3_i) && is_signed_op1(bus.funct3_i)
                    && (bus.op1_i == MOST_NEG) && (bus.op2_i == '1);
  assign special  = div_zero | div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = is_rem(bus.funct3_i) ? bus.op1_i : '1;
    end else if (div_ovf) begin
      special_res = is_rem(bus.funct3_i) ? '0 : bus.op1_i;
    end
  end

  assign sgn1 = is_signed_op1(f3_q) & op1_q[XLEN-1];
  assign sgn2 = is_signed_op2(f3_q) & op2_q[XLEN-1];
  assign mag1 = sgn1 ? -op1_q : op1_q;
  assign mag2 = sgn2 ? -op2_q : op2_q;

  muldiv_step #(.XLEN(XLEN), .BPC(BPC)) u_step (
    .div_op   (is_div(f3_q)),
    .acc      (acc_q),
    .operand  (divisor_q),
    .acc_next (acc_step)
  );

  // Signs are applied to magnitudes after the unsigned core has finished.
  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = neg_r ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = '0;
    case (f3_q)
      INST_MUL:                          fix_res = prod_fix[XLEN-1:0];
      INST_MULH, INST_MULHSU, INST_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      INST_DIV, INST_DIVU:               fix_res = quo_fix;
      default:                           fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bus.busy_o   = (state != IDLE);
    bus.done_o   = (state == DONE);
    bus.result_o = (state == DONE) ? res_q : '0;
    bus.stall_o  = bus.start_i & (state != DONE) & ~bus.flush_i;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : PREP;
      PREP:    state_nxt = CALC;
      CALC:    if (cnt_q == '0) state_nxt = FIXUP;
      FIXUP:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      f3_q      <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      divisor_q <= '0;
      res_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            f3_q  <= bus.funct3_i;
            op1_q <= bus.op1_i;
            op2_q <= bus.op2_i;
            if (special) res_q <= special_res;
          end
        end
        PREP: begin
          acc_q     <= {{XLEN{1'b0}}, mag1};
          divisor_q <= mag2;
          neg_q     <= sgn1 ^ sgn2;
          neg_r     <= sgn1;
          cnt_q     <= CNT_INIT;
        end
        CALC: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q - 1'b1;
        end
        FIXUP: res_q <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_muldiv_iter.sv
// Scoreboarded bench for two instances (BPC=1 and BPC=4, XLEN=32) against an arithmetic model.
module tb_exe_muldiv_iter;
  import muldiv_defs::*;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic        start [2];
  logic        flush [2];
  logic [2:0]  f3    [2];
  logic [31:0] op1   [2];
  logic [31:0] op2   [2];
  logic        stall_w [2];
  logic        busy_w  [2];
  logic        done_w  [2];
  logic [31:0] result_w[2];

  int cyc = 0;
  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  exe_muldiv_iter_if #(.XLEN(32)) bus0 ();
  exe_muldiv_iter_if #(.XLEN(32)) bus1 ();

  assign bus0.start_i = start[0];  assign bus1.start_i = start[1];
  assign bus0.flush_i = flush[0];  assign bus1.flush_i = flush[1];
  assign bus0.funct3_i = f3[0];    assign bus1.funct3_i = f3[1];
  assign bus0.op1_i = op1[0];      assign bus1.op1_i = op1[1];
  assign bus0.op2_i = op2[0];      assign bus1.op2_i = op2[1];
  assign stall_w[0] = bus0.stall_o;   assign stall_w[1] = bus1.stall_o;
  assign busy_w[0] = bus0.busy_o;     assign busy_w[1] = bus1.busy_o;
  assign done_w[0] = bus0.done_o;     assign done_w[1] = bus1.done_o;
  assign result_w[0] = bus0.result_o; assign result_w[1] = bus1.result_o;

  exe_muldiv_iter #(.XLEN(32), .BPC(1)) u_dut0 (.clk_i(clk), .rst_i(rst[0]), .bus(bus0));
  exe_muldiv_iter #(.XLEN(32), .BPC(4)) u_dut1 (.clk_i(clk), .rst_i(rst[1]), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d cycle %0d: got %h, expected %h", nm, k, cyc, act, exp);
  endtask

  // Reference model: plain integer arithmetic following the RISC-V M rules.
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa = $signed(a);
    sb = $signed(b);
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = '0;
    case (f)
      3'b000: begin p = 64'(ua * ub); return p[31:0]; end
      3'b001: begin p = 64'(sa * sb); return p[63:32]; end
      3'b010: begin p = 64'(sa * ub); return p[63:32]; end
      3'b011: begin p = 64'(ua * ub); return p[63:32]; end
      3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input int k, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bit quick;
    quick = f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    return quick ? 1 : ((k == 0) ? 32 : 8) + 3;
  endfunction

  // Drives one op and holds start_i until done_o; b2b means issuing in the previous DONE cycle.
  task automatic issue(input int k, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit b2b);
    int c0, lat;
    exp_t e;
    if (!b2b) @(negedge clk);
    start[k] = 1'b1; f3[k] = f; op1[k] = a; op2[k] = b;
    c0  = b2b ? cyc + 1 : cyc;
    lat = ref_lat(k, f, a, b);
    e.res = ref_res(f, a, b);
    e.cyc = c0 + lat;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    #1;
    for (int i = 0; i < 200; i++) begin
      if (cyc >= c0) chk("stall", k, 64'(stall_w[k]), 64'(cyc != c0 + lat));
      if (cyc >= c0 && done_w[k]) break;
      if (i == 199) begin
        n_total++;
        $display("FAIL timeout dut%0d: no done_o, expected at cycle %0d", k, c0 + lat);
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic release_op(input int k);
    start[k] = 1'b0;
  endtask

  // Starts a DIV, then flushes or resets it at cycle 10.
  task automatic abort(input int k, input bit use_rst);
    @(negedge clk);
    start[k] = 1'b1; f3[k] = INST_DIV; op1[k] = 32'hFFFF_FF9C; op2[k] = 32'd3;
    repeat (10) @(negedge clk);
    if (use_rst) rst[k] = 1'b1;
    else begin
      flush[k] = 1'b1;
      #1 chk("stall_on_flush", k, 64'(stall_w[k]), 64'd0);
    end
    @(negedge clk);
    start[k] = 1'b0; flush[k] = 1'b0; rst[k] = 1'b0;
    #1;
    chk(use_rst ? "busy_after_rst" : "busy_after_flush", k, 64'(busy_w[k]), 64'd0);
    chk("done_after_abort", k, 64'(done_w[k]), 64'd0);
    chk("result_after_abort", k, 64'(result_w[k]), 64'd0);
    chk("stall_after_abort", k, 64'(stall_w[k]), 64'd0);
  endtask

  // Monitor: every done_o must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (done_w[k]) begin
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          n_total++;
          $display("FAIL unexpected_done dut%0d cycle %0d: result %h, expected no done_o", k, cyc, result_w[k]);
        end else begin
          exp_t e;
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          chk("result", k, 64'(result_w[k]), 64'(e.res));
          chk("done_cycle", k, 64'(cyc), 64'(e.cyc));
        end
      end else if (!rst[k]) begin
        chk("result_zero_idle", k, 64'(result_w[k]), 64'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [2:0]  df [11];
  logic [31:0] da [11];
  logic [31:0] db [11];
  bit b2b_cur, b2b_nxt;

  initial begin
    df = '{INST_MUL, INST_MULHU, INST_MULH, INST_MULHSU, INST_DIV, INST_REM,
           INST_DIVU, INST_REMU, INST_DIV, INST_REMU, INST_DIV};
    da = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
           32'd100, 32'd100, 32'd1234, 32'd5, 32'h8000_0000};
    db = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2,
           32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF};
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; start[k] = 1'b0; flush[k] = 1'b0;
      f3[k] = '0; op1[k] = '0; op2[k] = '0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_busy", k, 64'(busy_w[k]), 64'd0);
      chk("reset_done", k, 64'(done_w[k]), 64'd0);
      chk("reset_stall", k, 64'(stall_w[k]), 64'd0);
      chk("reset_result", k, 64'(result_w[k]), 64'd0);
    end

    for (int i = 0; i < 11; i++) begin
      issue(0, df[i], da[i], db[i], 1'b0);
      release_op(0);
    end
    issue(0, INST_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    release_op(0);

    abort(0, 1'b0);
    issue(0, INST_DIVU, 32'd9, 32'd3, 1'b0);
    release_op(0);
    abort(0, 1'b1);

    @(negedge clk);
    start[0] = 1'b1; flush[0] = 1'b1; f3[0] = INST_DIVU; op1[0] = 32'd9; op2[0] = 32'd3;
    #1 chk("stall_start_flush", 0, 64'(stall_w[0]), 64'd0);
    @(negedge clk);
    start[0] = 1'b0; flush[0] = 1'b0;
    #1 chk("busy_start_flush", 0, 64'(busy_w[0]), 64'd0);

    issue(1, INST_DIVU, 32'hFFFF_FFFF, 32'h10, 1'b0);
    release_op(1);
    issue(1, INST_MUL, 32'd12345, 32'd678, 1'b0);
    issue(1, INST_MUL, 32'hFFFF_FFF0, 32'd3, 1'b1);
    release_op(1);

    for (int k = 0; k < 2; k++) begin
      b2b_cur = 1'b0;
      for (int i = 0; i < 24; i++) begin
        logic [2:0]  f;
        logic [31:0] a, b;
        f = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 5))
          0: a = 32'h0;  1: a = 32'hFFFF_FFFF;  2: a = 32'h8000_0000;
          3: a = 32'($urandom_range(0, 15));  default: a = $urandom;
        endcase
        case ($urandom_range(0, 5))
          0: b = 32'h0;  1: b = 32'hFFFF_FFFF;  2: b = 32'h8000_0000;
          3: b = 32'($urandom_range(0, 15));  default: b = $urandom;
        endcase
        b2b_nxt = ($urandom_range(0, 2) == 0) && (i != 23);
        issue(k, f, a, b, b2b_cur);
        if (!b2b_nxt) release_op(k);
        b2b_cur = b2b_nxt;
      end
    end

    repeat (5) @(negedge clk);
    chk("pending_dut0", 0, 64'(q0.size()), 64'd0);
    chk("pending_dut1", 1, 64'(q1.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exe_muldiv_iter.md
Name: exe_muldiv_iter

Overview:
- Parametrised iterative RV32M/RV64M multiply/divide unit for the execute stage; the successor to the fixed-latency M-type datapath.
- Accepts one M-extension op from the execute stage and holds the pipeline via stall_o until the result is ready.
- Bits-per-cycle, and therefore latency, is configurable.
- Handles RISC-V divide-by-zero and signed-overflow rules, plus a flush from pipe_ctrl.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- BPC, 1, quotient/product bits retired per CALC cycle (1, 2 or 4); XLEN % BPC == 0.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  valid M-type instruction present in exe (opcode R_M, funct7 = 0000001)
- funct3_i  in  3  MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
- op1_i  in  XLEN  rs1 value
- op2_i  in  XLEN  rs2 value
- flush_i  in  1  pipe_ctrl flush; aborts the current op
- stall_o  out  1  stall request to pipe_ctrl
- busy_o  out  1  FSM not IDLE
- done_o  out  1  one-cycle result strobe
- result_o  out  XLEN  rd data; valid only when done_o = 1, else 0

Behaviour:
- Reset (rst_i = 1 at posedge): state = IDLE; accumulators cleared.
  - Outputs: stall_o = 0, busy_o = 0, done_o = 0, result_o = 0.
  - Reset overrides every other input, including mid-operation.
- stall_o = start_i & ~done_o & ~flush_i (combinational). The execute stage holds op1_i/op2_i/funct3_i stable while stall_o = 1.
- Operands and funct3 are latched on the IDLE cycle with start_i = 1; inputs during later states are ignored.
- States: IDLE -> PREP -> CALC -> FIXUP -> DONE -> IDLE.
- IDLE:
  - If start_i & ~flush_i: latch operands, go to PREP.
  - Special case: divide op with op2 == 0 goes straight to DONE.
  - Special case: DIV/REM with op1 = most-negative and op2 = all-ones goes straight to DONE.
- PREP:
  - Convert signed operands to magnitudes and record result sign.
  - Signedness: MULHSU treats op2 as unsigned. Unsigned ops pass through.
  - Load counter = XLEN/BPC - 1.
- CALC:
  - Multiply: shift-add, BPC bits per cycle, into a 2*XLEN product.
  - Divide: restoring, BPC quotient bits per cycle.
  - Counter decrements; go to FIXUP at counter == 0.
- FIXUP:
  - Apply sign. Quotient sign = sign(op1) xor sign(op2); remainder sign = sign(op1).
  - Select the result: MUL = product[XLEN-1:0]; MULH* = product[2XLEN-1:XLEN].
- DONE: done_o = 1, result_o driven, stall_o = 0. Always returns to IDLE; the following cycle's start_i is a new instruction.
- Latency: the first start_i cycle is cycle 0.
  - Normal op: done_o at cycle XLEN/BPC + 3.
  - Special cases: done_o at cycle 1.
- Divide-by-zero: DIV/DIVU result = all ones; REM/REMU result = op1.
- Signed overflow: DIV result = op1; REM result = 0.
- Flush:
  - flush_i = 1 in any state: next state IDLE, no done_o.
  - flush_i = 1 together with start_i in IDLE: nothing is accepted.
  - flush_i in the DONE cycle: done_o is still asserted; the consumer discards it.
- Back-to-back ops: IDLE is entered after DONE, so a new op starts the cycle after done_o with no lost cycles beyond that.
- Width rules: all internal arithmetic is unsigned XLEN+1 / 2XLEN bits. No overflow traps.

Decomposition:
- Package muldiv_defs holds:
  - funct3 encodings (INST_MUL .. INST_REMU);
  - state encoding (IDLE, PREP, CALC, FIXUP, DONE);
  - is_div(funct3) and is_signed_op1/op2(funct3) helper constants.
- Sub-module muldiv_step (combinational, parametrised by XLEN and BPC): one CALC iteration for both shift-add and restoring divide. The FSM, counter and sign handling stay in exe_muldiv_iter.

Test Plan (XLEN = 32, BPC = 1 unless noted):
- MUL 7 × (-3): start_i held until done -> done_o at cycle 35, result_o = 0xFFFFFFEB; stall_o = 1 cycles 0..34, 0 at cycle 35.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 % 7 -> 2.
- DIV x / 0 -> 0xFFFFFFFF with done_o at cycle 1; REMU 5 % 0 -> 5. DIV 0x80000000 / -1 -> 0x80000000; REM -> 0; both done_o at cycle 1.
- flush_i pulsed at cycle 10 of a DIV -> busy_o = 0 at cycle 11, no done_o; the next DIVU 9/3 completes normally -> 3. Repeat with rst_i at cycle 10: all outputs 0 next cycle.
- BPC = 4: DIVU 0xFFFFFFFF / 0x10 -> 0x0FFFFFFF with done_o at cycle 11. Two back-to-back MULs -> second done_o exactly 12 cycles after the first.
